// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output ovf is built when DIGIT_SUB_OVF_EN is defined.
module digit_serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef DIGIT_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 4) ? $clog2(NDIG) : 2;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             borrow_q;
    logic             borrow_d;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] dig_d;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;
`ifdef DIGIT_SUB_OVF_EN
    logic             msb_bin_d;
    logic             ovf_q;
`endif

    // Ripple one digit of the shifted operands; the result digit enters res at the top.
    always_comb begin : ripple
        logic br;
        br    = borrow_q;
        dig_d = '0;
`ifdef DIGIT_SUB_OVF_EN
        msb_bin_d = 1'b0;
`endif
        for (int unsigned i = 0; i < DIGIT; i++) begin
`ifdef DIGIT_SUB_OVF_EN
            if (i == DIGIT - 1) msb_bin_d = br;
`endif
            dig_d[i] = a_q[i] ^ b_q[i] ^ br;
            br       = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
        end
        borrow_d = br;
        res_d    = (res_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef DIGIT_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    borrow_q <= borrow_d;
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= borrow_d;
                        zero_q  <= (res_d == '0);
`ifdef DIGIT_SUB_OVF_EN
                        ovf_q   <= msb_bin_d ^ borrow_d;
`endif
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef DIGIT_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: WIDTH=8 with DIGIT=2 (main), 1 and 8 sharing stimulus.
module tb_digit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;

    logic       busy2, done2, bout2, zero2;
    logic [7:0] diff2;
    logic       busy1, done1, bout1, zero1;
    logic [7:0] diff1;
    logic       busy8, done8, bout8, zero8;
    logic [7:0] diff8;
`ifdef DIGIT_SUB_OVF_EN
    logic       ovf2, ovf1, ovf8;
`endif

    int comp = 0;
    int errs = 0;

    logic [7:0] last_diff;
    logic       last_bout, last_zero, last_ovf;

    always #5 clk = ~clk;

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .zero(zero2)
`ifdef DIGIT_SUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1)
`ifdef DIGIT_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
`ifdef DIGIT_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // Reference arithmetic straight from the integer definition.
    function automatic logic [7:0] m_diff(logic [7:0] x, logic [7:0] y, logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return r[7:0];
    endfunction

    function automatic logic m_bout(logic [7:0] x, logic [7:0] y, logic c);
        return int'(x) < int'(y) + int'(c);
    endfunction

    function automatic logic m_ovf(logic [7:0] x, logic [7:0] y, logic c);
        int sx, sy, s;
        sx = x[7] ? int'(x) - 256 : int'(x);
        sy = y[7] ? int'(y) - 256 : int'(y);
        s  = sx - sy - int'(c);
        return (s < -128) || (s > 127);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comp++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the DIGIT=2 unit; latency counts edges inclusive of the start-sampling edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input bit inject, input string tag);
        int n, nbusy;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nbusy = 0;
        while (!done2 && n < 40) begin
            if (busy2) nbusy++;
            chk({tag, "/hold"}, diff2, last_diff);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            start = (inject && n == 2);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "/latency"}, n, 5);
        chk({tag, "/busy_cycles"}, nbusy, 4);
        chk({tag, "/diff"}, diff2, m_diff(ta, tb, tbin));
        chk({tag, "/bout"}, bout2, m_bout(ta, tb, tbin));
        chk({tag, "/zero"}, zero2, m_diff(ta, tb, tbin) == 8'h00);
`ifdef DIGIT_SUB_OVF_EN
        chk({tag, "/ovf"}, ovf2, m_ovf(ta, tb, tbin));
`endif
        last_diff = m_diff(ta, tb, tbin);
        last_bout = m_bout(ta, tb, tbin);
        last_zero = (last_diff == 8'h00);
        last_ovf  = m_ovf(ta, tb, tbin);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, "/single_done"}, {busy2, done2}, 2'b00);
        end
        chk({tag, "/after_hold"}, diff2, last_diff);
    endtask

    initial begin
        logic [7:0] ra, rb, e1, e2, cur;
        logic       rc;
        int         d_first, d_second, k, p1, p2, p8;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        last_diff = '0; last_bout = 1'b0; last_zero = 1'b0; last_ovf = 1'b0;
        #12;
        chk("reset/outs", {busy2, done2, diff2, bout2, zero2}, 12'h000);
`ifdef DIGIT_SUB_OVF_EN
        chk("reset/ovf", ovf2, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, "basic");
        do_op(8'h00, 8'h01, 1'b0, 1'b0, "under");
        do_op(8'h10, 8'h10, 1'b1, 1'b0, "eq_bin");
        do_op(8'h00, 8'h00, 1'b1, 1'b0, "wrap");
        do_op(8'h42, 8'h42, 1'b0, 1'b0, "zero");
        do_op(8'h42, 8'h42, 1'b0, 1'b1, "inject");
        do_op(8'h05, 8'h03, 1'b0, 1'b0, "small");
        do_op(8'h80, 8'h01, 1'b0, 1'b0, "sovf");

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            do_op(ra, rb, rc, bit'($urandom_range(0, 1)), "rand");
        end

        // Back-to-back: start held high through DONE.
        e1 = m_diff(8'hC3, 8'h4D, 1'b1);
        e2 = m_diff(8'h17, 8'h9E, 1'b0);
        cur = last_diff;
        d_first = 0; d_second = 0; k = 0;
        @(negedge clk);
        a = 8'hC3; b = 8'h4D; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 8'h17; b = 8'h9E; bin = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (done2) begin
                k++;
                if (k == 1) begin cur = e1; d_first = n; end
                else begin cur = e2; d_second = n; end
            end
            chk("b2b/diff_track", diff2, cur);
            if (n == 6) begin
                chk("b2b/no_idle", busy2, 1'b1);
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b/first_done", d_first, 5);
        chk("b2b/spacing", d_second - d_first, 5);
        chk("b2b/bout2", bout2, m_bout(8'h17, 8'h9E, 1'b0));
        last_diff = e2;

        // Asynchronous reset in the middle of RUN.
        do_op(8'h00, 8'h01, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/outs", {busy2, done2, diff2, bout2, zero2}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        last_diff = '0; last_bout = 1'b0; last_zero = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("rst_mid/no_done", {done2, busy2}, 2'b00);
        end
        do_op(8'hA7, 8'h3B, 1'b1, 1'b0, "post_rst");

        // Same operation on DIGIT = 1, 2 and 8.
        for (int n = 0; n < 12; n++) @(negedge clk);
        p1 = 0; p2 = 0; p8 = 0;
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            if (done1 && p1 == 0) p1 = n;
            if (done2 && p2 == 0) p2 = n;
            if (done8 && p8 == 0) p8 = n;
            @(negedge clk);
        end
        chk("dig1/latency", p1, 9);
        chk("dig2/latency", p2, 5);
        chk("dig8/latency", p8, 2);
        chk("dig1/diff", {bout1, diff1}, {1'b0, 8'h7F});
        chk("dig8/diff", {bout8, diff8}, {1'b0, 8'h7F});
        chk("dig2/diff", {bout2, diff2}, {1'b0, 8'h7F});
`ifdef DIGIT_SUB_OVF_EN
        chk("dig1/ovf", ovf1, 1'b1);
        chk("dig8/ovf", ovf8, 1'b1);
        chk("dig2/ovf", ovf2, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, errs);
        $finish;
    end

endmodule
